lcd_char_queue: RTL and testbench

//  Upstream feeder for the LCD1602 character driver. Nios writes characters/commands

---
 rtl/lcd_char_queue.sv | 212 +++++++++++++++++++++
 tb/tb_lcd_char_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_queue.sv
// -----------------------------------------------------------------------------
// lcd_char_queue
//
// Feeds the LCD1602 character driver from a small memory-mapped slave.
// Characters and commands are written through the slave and queued in a FIFO.
// The queue presents them one at a time on a valid/ready port. After each
// handshake there is a minimum gap, so the panel is never sent bytes faster
// than it can accept them.
//
// Optional feature macro: LCD_CLEAR_HOLDOFF_EN
//   When this macro is defined, a handshake of a clear (0x01) or return-home
//   (0x02) command uses a longer holdoff of LONG_HOLDOFF cycles instead of
//   GAP_CYCLES.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      synchronous reset, active-high
//   address    0 = push data (rs=1), 1 = push command (rs=0),
//              2 = status,           3 = control
//   write      single-cycle write strobe
//   writedata  write payload
//   read       read strobe
//   readdata   registered read data, valid one cycle after the read strobe
//   out_valid  an entry is presented to the LCD driver
//   out_ready  the LCD driver accepts the entry
//   out_rs     register select of the presented entry (1 = char, 0 = command)
//   out_data   byte of the presented entry
//   overflow   sticky flag, set when a push is attempted while the FIFO is full
// -----------------------------------------------------------------------------
module lcd_char_queue #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int GAP_CYCLES   = 2000,
    parameter int LONG_HOLDOFF = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] address,
    input  logic       write,
    input  logic [7:0] writedata,
    input  logic       read,
    output logic [7:0] readdata,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_rs,
    output logic [7:0] out_data,
    output logic       overflow
);

    // The gap counter is sized for the larger holdoff. Both builds then share
    // one counter width.
    localparam int HOLD_MAX = (GAP_CYCLES > LONG_HOLDOFF) ? GAP_CYCLES : LONG_HOLDOFF;
    localparam int GW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP
    } state_t;

    state_t          state;
    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [GW-1:0]   gap;
    logic [GW-1:0]   reload;
    logic [8:0]      head;
    logic [4:0]      count_disp;
    logic            full;
    logic            empty;
    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            flush;
    logic            ctrl_wr;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign ctrl_wr  = write && (address == 2'd3);
    assign flush    = ctrl_wr && writedata[0];
    assign push_req = write && (address == 2'd0 || address == 2'd1);

    // Flush outranks everything else. A pushed byte is discarded, and a
    // handshake in the same cycle does not pop.
    // When the FIFO is full, a simultaneous pop frees the slot for the push.
    assign pop     = (state == PRESENT) && out_ready && !flush;
    assign push_ok = push_req && !flush && (!full || pop);

`ifdef LCD_CLEAR_HOLDOFF_EN
    logic long_hold;
    // The registered out_rs/out_data hold the entry that is handshaking now.
    assign long_hold = !out_rs && (out_data == 8'h01 || out_data == 8'h02);
    assign reload    = long_hold ? GW'(LONG_HOLDOFF - 1) : GW'(GAP_CYCLES - 1);
`else
    assign reload    = GW'(GAP_CYCLES - 1);
`endif

    // NOTE: every variable assigned in always_comb gets a value on all paths,
    // otherwise a latch is inferred.
    always_comb begin
        count_disp = 5'(count);
        if (32'(count) > 32'd31) begin
            count_disp = 5'd31;
        end
    end

    // NOTE: the storage array has no reset. Its contents are meaningless until
    // the pointers say otherwise, and resetting a RAM stops it mapping to
    // memory macros.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {(address == 2'd0), writedata};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push_ok && !pop) begin
                    count <= count + (AW+1)'(1);
                end else if (pop && !push_ok) begin
                    count <= count - (AW+1)'(1);
                end
            end

            if (push_req && !flush && full && !pop) begin
                overflow <= 1'b1;
            end else if (ctrl_wr && writedata[1]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Output sequencer. When the gap expires and an entry is waiting, it is
    // presented directly. The next valid therefore follows a handshake by
    // exactly GAP_CYCLES+1 cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gap       <= '0;
            out_valid <= 1'b0;
            out_rs    <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty && !flush) begin
                        out_rs    <= head[8];
                        out_data  <= head[7:0];
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (flush) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        gap       <= reload;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (gap != '0) begin
                        gap <= gap - GW'(1);
                    end else if (!empty && !flush) begin
                        out_rs    <= head[8];
                        out_data  <= head[7:0];
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 8'h00;
        end else if (read) begin
            unique case (address)
                2'd2:    readdata <= {full, empty, 1'b0, count_disp};
                2'd3:    readdata <= {7'b0, overflow};
                default: readdata <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_queue.sv
// -----------------------------------------------------------------------------
// tb_lcd_char_queue
//
// Directed bench for lcd_char_queue with a short gap and a shallow FIFO.
// Inputs change one time unit after the rising edge. Outputs are sampled at
// the same point, before the next edge.
// -----------------------------------------------------------------------------
module tb_lcd_char_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int GAP   = 4;
    localparam int LONG  = 20;

`ifdef LCD_CLEAR_HOLDOFF_EN
    localparam int CLEAR_SPACING = LONG + 1;
`else
    localparam int CLEAR_SPACING = GAP + 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] address;
    logic       write;
    logic [7:0] writedata;
    logic       read;
    logic [7:0] readdata;
    logic       out_valid;
    logic       out_ready;
    logic       out_rs;
    logic [7:0] out_data;
    logic       overflow;

    int n_cmp  = 0;
    int n_fail = 0;
    int n;

    lcd_char_queue #(
        .DEPTH        (DEPTH),
        .AW           (AW),
        .GAP_CYCLES   (GAP),
        .LONG_HOLDOFF (LONG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .read      (read),
        .readdata  (readdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rs    (out_rs),
        .out_data  (out_data),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        read    = 1'b1;
        tick();
        read    = 1'b0;
    endtask

    // Counts cycles until out_valid rises, starting from a handshake cycle.
    // The count is bounded, so a stuck design cannot hang the run.
    task automatic gap_to_next(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!out_valid && cycles < 64);
    endtask

    initial begin
        reset     = 1'b1;
        address   = 2'd0;
        write     = 1'b0;
        writedata = 8'h00;
        read      = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_rs", 32'(out_rs), 32'd0);
        check("rst_data", 32'(out_data), 32'h00);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_rdata", 32'(readdata), 32'h00);
        bus_read(2'd2);
        check("rst_status", 32'(readdata), 32'h40);

        // 1: single character, latency N+2
        out_ready = 1'b1;
        bus_write(2'd0, 8'h41);
        check("t1_valid_n1", 32'(out_valid), 32'd0);
        tick();
        check("t1_valid_n2", 32'(out_valid), 32'd1);
        check("t1_rs", 32'(out_rs), 32'd1);
        check("t1_data", 32'(out_data), 32'h41);
        tick();
        check("t1_valid_after_hs", 32'(out_valid), 32'd0);
        check("t1_data_held", 32'(out_data), 32'h41);
        repeat (8) tick();

        // 2: back-to-back entries are spaced GAP+1 after the handshake
        bus_write(2'd0, 8'h48);
        bus_write(2'd0, 8'h49);
        check("t2_first_valid", 32'(out_valid), 32'd1);
        check("t2_first_data", 32'(out_data), 32'h48);
        gap_to_next(n);
        check("t2_spacing", 32'(n), 32'(GAP + 1));
        check("t2_second_data", 32'(out_data), 32'h49);
        check("t2_second_rs", 32'(out_rs), 32'd1);
        tick();
        repeat (8) tick();

        // 3: overflow on the fifth push, status, clear overflow
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus_write(2'd0, 8'(i));
        end
        check("t3_ovf_set", 32'(overflow), 32'd1);
        bus_read(2'd2);
        check("t3_status_full", 32'(readdata), 32'h84);
        bus_read(2'd3);
        check("t3_ctrl_read", 32'(readdata), 32'h01);
        bus_write(2'd3, 8'h02);
        check("t3_ovf_clr", 32'(overflow), 32'd0);
        tick();
        check("t3_rdata_hold", 32'(readdata), 32'h01);

        // 4: stall holds the entry stable, then flush
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_valid_stall", 32'(out_valid), 32'd1);
            check("t4_data_stall", 32'(out_data), 32'h01);
            check("t4_rs_stall", 32'(out_rs), 32'd1);
        end
        bus_read(2'd2);
        check("t4_status_stall", 32'(readdata), 32'h84);
        bus_write(2'd3, 8'h01);
        check("t4_flush_valid", 32'(out_valid), 32'd0);
        bus_read(2'd2);
        check("t4_status_flushed", 32'(readdata), 32'h40);
        check("t4_ovf_kept", 32'(overflow), 32'd0);

        // 5: clear command holdoff
        out_ready = 1'b1;
        bus_write(2'd1, 8'h01);
        bus_write(2'd0, 8'h5A);
        check("t5_cmd_valid", 32'(out_valid), 32'd1);
        check("t5_cmd_rs", 32'(out_rs), 32'd0);
        check("t5_cmd_data", 32'(out_data), 32'h01);
        gap_to_next(n);
        check("t5_spacing", 32'(n), 32'(CLEAR_SPACING));
        check("t5_next_data", 32'(out_data), 32'h5A);
        tick();
        repeat (30) tick();

        // 6: push and handshake in the same cycle while full
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_write(2'd0, 8'hA0 + 8'(i));
        end
        check("t6_present", 32'(out_data), 32'hA0);
        out_ready = 1'b1;
        bus_write(2'd0, 8'hA4);
        out_ready = 1'b0;
        check("t6_valid_dropped", 32'(out_valid), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);
        bus_read(2'd2);
        check("t6_status_full", 32'(readdata), 32'h84);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            gap_to_next(n);
            check("t6_drain_valid", 32'(out_valid), 32'd1);
            check("t6_drain_data", 32'(out_data), 32'hA0 + 32'(k));
        end
        repeat (8) tick();
        bus_read(2'd2);
        check("t6_status_empty", 32'(readdata), 32'h40);

        // Reset in the middle of operation
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_write(2'd0, 8'h30 + 8'(i));
        end
        bus_read(2'd3);
        check("mid_ovf_before", 32'(overflow), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_rs", 32'(out_rs), 32'd0);
        check("mid_data", 32'(out_data), 32'h00);
        check("mid_ovf", 32'(overflow), 32'd0);
        check("mid_rdata", 32'(readdata), 32'h00);
        bus_read(2'd2);
        check("mid_status", 32'(readdata), 32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
